// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port block RAM between the fetch and data ports,
// data first, with a starvation guard that forces a fetch grant after a run of data grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_en,
    output logic [3:0]        mem_wea,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state, next_state;
    logic          gnt_d;
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          force_if, grant_any, grant_d, lat_done, starve_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state == IDLE  ? (grant_any ? ISSUE : IDLE) :
                     state == ISSUE ? WAIT :
                     state == WAIT  ? (lat_done ? RESP : WAIT) : IDLE;
    end

    always_comb begin
        starve_full = starve_cnt == SW'(STARVE_MAX);
        force_if    = if_req && starve_full;
        grant_any   = if_req || d_req;
        grant_d     = d_req && !force_if;
        lat_done    = lat_cnt == LW'(MEM_LAT);
        if_stall    = if_req && !if_valid;
        d_stall     = d_req && !d_valid;
    end

    // valids default low every cycle so they only stand for the single RESP cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en     <= 1'b0;
            mem_wea    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            gnt_d      <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            if (state == IDLE && grant_any) begin
                mem_en     <= 1'b1;
                mem_addr   <= grant_d ? d_addr : if_addr;
                mem_wea    <= grant_d ? d_we : 4'b0000;
                mem_wdata  <= grant_d ? d_wdata : '0;
                gnt_d      <= grant_d;
                starve_cnt <= !grant_d || !if_req ? '0 :
                              starve_full ? starve_cnt : starve_cnt + SW'(1);
            end
            if (state == ISSUE) begin
                mem_en  <= 1'b0;
                mem_wea <= '0;
                lat_cnt <= LW'(1);
            end
            if (state == WAIT && !lat_done) lat_cnt <= lat_cnt + LW'(1);
            if (state == WAIT && lat_done && gnt_d) begin
                d_rdata <= mem_rdata;
                d_valid <= 1'b1;
            end
            if (state == WAIT && lat_done && !gnt_d) begin
                if_rdata <= mem_rdata;
                if_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter against behavioural RAMs,
// instance 0 with MEM_LAT=1 and instance 1 with MEM_LAT=3.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req   [2];
    logic [31:0] if_addr  [2];
    logic [31:0] if_rdata [2];
    logic        if_valid [2];
    logic        if_stall [2];
    logic        d_req    [2];
    logic [3:0]  d_we     [2];
    logic [31:0] d_addr   [2];
    logic [31:0] d_wdata  [2];
    logic [31:0] d_rdata  [2];
    logic        d_valid  [2];
    logic        d_stall  [2];
    logic        mem_en   [2];
    logic [3:0]  mem_wea  [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata[2];
    logic [31:0] mem_rdata[2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        return i == 0 ? 32'h2008_0005 : 32'h1122_3300 + 32'(i);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = g == 0 ? 1 : 3;
        logic [31:0] ram  [256];
        logic [31:0] pipe [LAT];

        initial for (int i = 0; i < 256; i++) ram[i] = init_word(i);

        always @(posedge clk) begin
            if (mem_en[g]) begin
                pipe[0] <= ram[mem_addr[g][9:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wea[g][b]) ram[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];

        mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(LAT), .STARVE_MAX(4)) dut (
            .clk(clk), .rst(rst),
            .if_req(if_req[g]), .if_addr(if_addr[g]), .if_rdata(if_rdata[g]),
            .if_valid(if_valid[g]), .if_stall(if_stall[g]),
            .d_req(d_req[g]), .d_we(d_we[g]), .d_addr(d_addr[g]), .d_wdata(d_wdata[g]),
            .d_rdata(d_rdata[g]), .d_valid(d_valid[g]), .d_stall(d_stall[g]),
            .mem_en(mem_en[g]), .mem_wea(mem_wea[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int n, first, second, stale;
        logic [5:0] seq;
        for (int g = 0; g < 2; g++) begin
            if_req[g] = 0; if_addr[g] = 0; d_req[g] = 0; d_we[g] = 0; d_addr[g] = 0; d_wdata[g] = 0;
        end
        step(2);
        check("rst_mem_en", 64'(mem_en[0]), 0);
        check("rst_mem_addr", 64'(mem_addr[0]), 0);
        check("rst_valids", 64'({if_valid[0], d_valid[0], if_valid[1], d_valid[1]}), 0);
        check("rst_rdata", 64'({if_rdata[0], d_rdata[0]}), 0);
        rst = 1'b1;
        step();

        // single fetch, MEM_LAT=1
        if_req[0] = 1; if_addr[0] = 32'h0;
        #1 check("t1_stall_c0", 64'(if_stall[0]), 1);
        step();
        check("t1_mem_en_c1", 64'(mem_en[0]), 1);
        check("t1_mem_addr_c1", 64'(mem_addr[0]), 0);
        check("t1_mem_wea_c1", 64'(mem_wea[0]), 0);
        check("t1_stall_c1", 64'(if_stall[0]), 1);
        step();
        check("t1_mem_en_c2", 64'(mem_en[0]), 0);
        check("t1_valid_c2", 64'(if_valid[0]), 0);
        check("t1_stall_c2", 64'(if_stall[0]), 1);
        step();
        check("t1_valid_c3", 64'(if_valid[0]), 1);
        check("t1_rdata_c3", 64'(if_rdata[0]), 64'h2008_0005);
        check("t1_stall_c3", 64'(if_stall[0]), 0);
        if_req[0] = 0;
        step();
        check("t1_valid_c4", 64'(if_valid[0]), 0);

        // simultaneous requests: data wins, fetch follows
        if_req[0] = 1; if_addr[0] = 32'h4;
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h40;
        step();
        check("t2_mem_addr_c1", 64'(mem_addr[0]), 64'h40);
        step(2);
        check("t2_d_valid_c3", 64'(d_valid[0]), 1);
        check("t2_d_rdata_c3", 64'(d_rdata[0]), 64'h1122_3310);
        check("t2_if_valid_c3", 64'(if_valid[0]), 0);
        d_req[0] = 0;
        step();
        check("t2_mem_en_c4", 64'(mem_en[0]), 0);
        step();
        check("t2_mem_en_c5", 64'(mem_en[0]), 1);
        check("t2_mem_addr_c5", 64'(mem_addr[0]), 64'h4);
        step(2);
        check("t2_if_valid_c7", 64'(if_valid[0]), 1);
        check("t2_if_rdata_c7", 64'(if_rdata[0]), 64'h1122_3301);
        if_req[0] = 0;
        step();

        // halfword store then reload
        d_req[0] = 1; d_we[0] = 4'b0011; d_addr[0] = 32'h8; d_wdata[0] = 32'hAABB_CCDD;
        step();
        check("t3_wea_c1", 64'(mem_wea[0]), 64'b0011);
        check("t3_wdata_c1", 64'(mem_wdata[0]), 64'hAABB_CCDD);
        step();
        check("t3_wea_c2", 64'(mem_wea[0]), 0);
        step();
        check("t3_st_valid", 64'(d_valid[0]), 1);
        d_req[0] = 0;
        step();
        d_req[0] = 1; d_we[0] = 0;
        step(3);
        check("t3_ld_valid", 64'(d_valid[0]), 1);
        check("t3_ld_rdata", 64'(d_rdata[0]), 64'h1122_CCDD);
        d_req[0] = 0;
        step();

        // starvation guard with both requests held
        if_req[0] = 1; if_addr[0] = 32'h4; d_req[0] = 1; d_addr[0] = 32'h40;
        n = 0; seq = '0;
        for (int c = 0; c < 40 && n < 6; c++) begin
            step();
            if (d_valid[0] || if_valid[0]) begin
                seq = {seq[4:0], if_valid[0]};
                n++;
            end
        end
        if_req[0] = 0; d_req[0] = 0;
        check("t4_count", 64'(n), 6);
        check("t4_order", 64'(seq), 64'b000010);
        step();

        // MEM_LAT=3 back-to-back fetches
        if_req[1] = 1; if_addr[1] = 32'hC;
        first = -1; second = -1;
        for (int c = 1; c <= 11; c++) begin
            step();
            if (if_valid[1]) begin
                if (first < 0) first = c;
                else second = c;
            end
        end
        if_req[1] = 0;
        check("t5_first_valid", 64'(first), 5);
        check("t5_second_valid", 64'(second), 11);
        check("t5_rdata", 64'(if_rdata[1]), 64'h1122_3303);
        step();

        // reset while waiting on the RAM
        d_req[0] = 1; d_we[0] = 0; d_addr[0] = 32'h40;
        step(2);
        #1 rst = 1'b0; d_req[0] = 0;
        #1;
        check("t6_mem_en", 64'(mem_en[0]), 0);
        check("t6_mem_addr", 64'(mem_addr[0]), 0);
        check("t6_mem_wdata", 64'(mem_wdata[0]), 0);
        check("t6_rdata", 64'({if_rdata[0], d_rdata[0]}), 0);
        check("t6_valid", 64'({if_valid[0], d_valid[0]}), 0);
        step();
        rst = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (d_valid[0] || if_valid[0]) stale++;
        end
        check("t6_no_stale", 64'(stale), 0);
        d_req[0] = 1; d_addr[0] = 32'h8;
        step(3);
        check("t6_re_valid", 64'(d_valid[0]), 1);
        check("t6_re_rdata", 64'(d_rdata[0]), 64'h1122_CCDD);
        d_req[0] = 0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
